// File: rtl/uart_fabric_pkg.sv
// Shared types and constants for the UART register-bus fabric.
package uart_fabric_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } fab_state_t;

    localparam logic [2:0]  LOCAL_SEL    = 3'd7;

    localparam logic [3:0]  OFF_IRQ_MASK = 4'd0;
    localparam logic [3:0]  OFF_IRQ_STAT = 4'd1;
    localparam logic [3:0]  OFF_CH_RST   = 4'd2;
    localparam logic [3:0]  OFF_ERR_STAT = 4'd3;

    localparam logic [31:0] ERR_RDATA    = 32'hFFFF_FFFF;

    localparam int          ERR_FLAG_BIT = 3;

endpackage

// File: rtl/uart_fabric_lreg.sv
// Wrapper-local registers: interrupt mask, per-channel soft reset, sticky timeout
// status, registered interrupt aggregation and the local read mux.
module uart_fabric_lreg import uart_fabric_pkg::*; #(
    parameter int NUM_CH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [3:0]        addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [NUM_CH-1:0] ch_irq_i,
    input  logic              to_set_i,
    input  logic [2:0]        to_ch_i,
    output logic [31:0]       rdata_o,
    output logic [NUM_CH-1:0] ch_rst_n_o,
    output logic              irq_o
);

    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] ch_rst_q;
    logic [3:0]        err_stat_q;
    logic              irq_q;
    logic              unused_wdata;

    assign unused_wdata = ^wdata_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask_q     <= '0;
            ch_rst_q   <= '1;
            err_stat_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_q <= |(ch_irq_i & mask_q);
            if (wr_en_i && addr_i == OFF_IRQ_MASK) begin
                mask_q <= wdata_i[NUM_CH-1:0];
            end
            if (wr_en_i && addr_i == OFF_CH_RST) begin
                ch_rst_q <= wdata_i[NUM_CH-1:0];
            end
            // A timeout landing on the same cycle as a software clear must stay visible.
            if (to_set_i) begin
                err_stat_q <= {1'b1, to_ch_i};
            end else if (wr_en_i && addr_i == OFF_ERR_STAT && wdata_i[ERR_FLAG_BIT]) begin
                err_stat_q[ERR_FLAG_BIT] <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        case (addr_i)
            OFF_IRQ_MASK: rdata_o = 32'(mask_q);
            OFF_IRQ_STAT: rdata_o = 32'(ch_irq_i);
            OFF_CH_RST:   rdata_o = 32'(ch_rst_q);
            OFF_ERR_STAT: rdata_o = 32'(err_stat_q);
            default:      rdata_o = '0;
        endcase
    end

    assign ch_rst_n_o = ~ch_rst_q;
    assign irq_o      = irq_q;

endmodule

// File: rtl/uart_reg_fabric.sv
// Register-bus fabric in front of NUM_CH UART channels: tracks one access at a time,
// times out silent channels with an error response and hosts the local register block.
module uart_reg_fabric import uart_fabric_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int TO_CYC = 64,
    parameter int CH_DW  = 8
) (
    input  logic                    app_clk,
    input  logic                    app_rst,
    input  logic                    reg_cs,
    input  logic                    reg_wr,
    input  logic [8:0]              reg_addr,
    input  logic [31:0]             reg_wdata,
    input  logic [3:0]              reg_be,
    output logic [31:0]             reg_rdata,
    output logic                    reg_ack,
    output logic                    reg_err,
    output logic [NUM_CH-1:0]       ch_cs,
    output logic                    ch_wr,
    output logic [3:0]              ch_addr,
    output logic [CH_DW-1:0]        ch_wdata,
    output logic                    ch_be,
    input  logic [NUM_CH*CH_DW-1:0] ch_rdata,
    input  logic [NUM_CH-1:0]       ch_ack,
    input  logic [NUM_CH-1:0]       ch_irq,
    output logic [NUM_CH-1:0]       ch_rst_n,
    output logic                    irq
);

    // state | meaning
    // IDLE  | waiting for reg_cs; request captured on exit
    // ISSUE | decode block: start channel access, do local access, or flag unmapped
    // WAIT  | ch_cs held, counting down to timeout until the selected channel acks
    // RESP  | one-cycle reg_ack with reg_err/reg_rdata valid

    fab_state_t        state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic              wr_q, wr_d;
    logic [3:0]        addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              be_q, be_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              sel_is_ch;
    logic              sel_ack;
    logic [CH_DW-1:0]  sel_rdata;
    logic              lreg_we;
    logic              to_set;
    logic [31:0]       lreg_rdata;
    logic              unused_be;

    assign unused_be = ^reg_be[3:1];
    assign sel_is_ch = ({29'd0, sel_q} < 32'(NUM_CH));

    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_q == 3'(i)) begin
                sel_ack   = ch_ack[i];
                sel_rdata = ch_rdata[i*CH_DW +: CH_DW];
            end
        end
    end

    always_ff @(posedge app_clk or posedge app_rst) begin
        if (app_rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        lreg_we = 1'b0;
        to_set  = 1'b0;

        case (state_q)
            IDLE: begin
                if (reg_cs) begin
                    sel_d   = reg_addr[8:6];
                    wr_d    = reg_wr;
                    addr_d  = reg_addr[5:2];
                    wdata_d = reg_wdata;
                    be_d    = reg_be[0];
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (sel_is_ch) begin
                    cnt_d   = 8'(TO_CYC - 1);
                    state_d = WAIT;
                end else if (sel_q == LOCAL_SEL) begin
                    lreg_we = wr_q & be_q;
                    rdata_d = lreg_rdata;
                    state_d = RESP;
                end else begin
                    err_d   = 1'b1;
                    rdata_d = ERR_RDATA;
                    state_d = RESP;
                end
            end
            WAIT: begin
                // Ack is checked first so an ack on the terminal-count cycle still succeeds.
                if (sel_ack) begin
                    rdata_d = 32'(sel_rdata);
                    state_d = RESP;
                end else if (cnt_q == 8'd0) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_RDATA;
                    to_set  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ch_cs = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_cs[i] = (state_q == WAIT) && (sel_q == 3'(i));
        end
    end

    assign ch_wr     = wr_q;
    assign ch_addr   = addr_q;
    assign ch_wdata  = wdata_q[CH_DW-1:0];
    assign ch_be     = be_q;

    assign reg_ack   = (state_q == RESP);
    assign reg_err   = (state_q == RESP) && err_q;
    assign reg_rdata = rdata_q;

    uart_fabric_lreg #(
        .NUM_CH (NUM_CH)
    ) u_lreg (
        .clk_i      (app_clk),
        .rst_i      (app_rst),
        .wr_en_i    (lreg_we),
        .addr_i     (addr_q),
        .wdata_i    (wdata_q),
        .ch_irq_i   (ch_irq),
        .to_set_i   (to_set),
        .to_ch_i    (sel_q),
        .rdata_o    (lreg_rdata),
        .ch_rst_n_o (ch_rst_n),
        .irq_o      (irq)
    );

endmodule
